// File: rtl/frame_rd_cmd_gen.sv
// -----------------------------------------------------------------------------
// frame_rd_cmd_gen
//
// Read-side command generator for the frame buffer bank switcher (ddr_clk
// domain). On every accepted frame_start it requests a read-bank switch
// (rd_sw / rd_sw_ack), latches the bank base address returned with the ack,
// then walks the frame line by line, issuing one AXI read burst command per
// burst slot. A command is only raised once the read FIFO reports room for
// a full burst (space_ok).
//
// Ports:
//   ddr_clk        clock
//   rst            synchronous reset, active-high
//   frame_start    one-cycle pulse, start of an output frame
//   vid_width      active pixels per line, sampled on accepted frame_start
//   vid_height     active lines, sampled on accepted frame_start
//   rd_sw          bank-switch request (level, held until ack)
//   rd_sw_ack      one-cycle acknowledge from the bank switcher
//   rd_start_addr  read bank base byte address, valid with rd_sw_ack
//   cmd_valid      burst command valid
//   cmd_ready      burst command accepted
//   cmd_addr       burst start byte address
//   cmd_len        burst length minus one (ARLEN encoding)
//   space_ok       downstream FIFO can absorb BURST_LEN beats
//   frame_busy     frame in progress
//   frame_done     one-cycle pulse after the last command of a frame
//   frame_drop     one-cycle pulse, same cycle as a frame_start seen while busy
//   ack_err        one-cycle pulse on rd_sw_ack timeout
//
// Optional feature (macro RD_SW_TIMEOUT_EN): bounds the wait for rd_sw_ack to
// ACK_TIMEOUT cycles. On expiry ack_err pulses and the frame proceeds with the
// previously latched base. Without the macro the request waits forever and
// ack_err is tied low.
// -----------------------------------------------------------------------------
module frame_rd_cmd_gen #(
  parameter int MAX_VID_WIDTH  = 1920,
  parameter int MAX_VID_HIGHT  = 1080,
  parameter int VID_DATA_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int BURST_LEN      = 16,
  parameter int ACK_TIMEOUT    = 1024
) (
  input  logic        ddr_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [11:0] vid_width,
  input  logic [11:0] vid_height,
  output logic        rd_sw,
  input  logic        rd_sw_ack,
  input  logic [31:0] rd_start_addr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_addr,
  output logic [7:0]  cmd_len,
  input  logic        space_ok,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        frame_drop,
  output logic        ack_err
);

  localparam int          AXI_BYTES   = AXI_DATA_WIDTH / 8;
  localparam logic [31:0] STRIDE      = 32'(MAX_VID_WIDTH * VID_DATA_WIDTH / 8);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * AXI_BYTES);
  localparam logic [7:0]  LEN_MAX     = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LINE,
    S_WAIT,
    S_ISSUE,
    S_FIN
  } state_t;

  state_t      state_reg;
  logic        rd_sw_reg;
  logic        cmd_valid_reg;
  logic [7:0]  cmd_len_reg;
  logic        frame_done_reg;
  logic [31:0] base_reg;         // bank base latched with rd_sw_ack
  logic [31:0] line_off_reg;     // line * STRIDE, accumulated
  logic [31:0] burst_addr_reg;   // address of the current/next burst
  logic [31:0] rem_reg;          // beats still to request on this line
  logic [31:0] line_beats_reg;
  logic [11:0] h_reg;
  logic [11:0] line_cnt_reg;

  // Frame geometry, evaluated from the inputs in the frame_start cycle.
  logic [31:0] w_clamp;
  logic [11:0] h_clamp;
  logic [31:0] line_bytes;
  logic [31:0] line_beats_in;
  logic [31:0] rem_after;

  always_comb begin
    w_clamp = ({20'd0, vid_width} > 32'(MAX_VID_WIDTH)) ? 32'(MAX_VID_WIDTH)
                                                         : {20'd0, vid_width};
    h_clamp = ({20'd0, vid_height} > 32'(MAX_VID_HIGHT)) ? 12'(MAX_VID_HIGHT)
                                                          : vid_height;
    line_bytes    = (w_clamp * 32'(VID_DATA_WIDTH)) / 32'd8;
    line_beats_in = (line_bytes + 32'(AXI_BYTES - 1)) / 32'(AXI_BYTES);
    // Beats left on the line once the command on the bus is accepted.
    rem_after     = rem_reg - {24'd0, cmd_len_reg} - 32'd1;
  end

`ifdef RD_SW_TIMEOUT_EN
  localparam int               ACK_CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_CW-1:0] ACK_CNT_LAST = ACK_CW'(ACK_TIMEOUT - 1);
  logic [ACK_CW-1:0] ack_cnt_reg;
  logic              ack_err_reg;
`endif

  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      rd_sw_reg      <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      cmd_len_reg    <= 8'd0;
      frame_done_reg <= 1'b0;
      base_reg       <= 32'd0;
      line_off_reg   <= 32'd0;
      burst_addr_reg <= 32'd0;
      rem_reg        <= 32'd0;
      line_beats_reg <= 32'd0;
      h_reg          <= 12'd0;
      line_cnt_reg   <= 12'd0;
`ifdef RD_SW_TIMEOUT_EN
      ack_cnt_reg    <= '0;
      ack_err_reg    <= 1'b0;
`endif
    end else begin
      frame_done_reg <= 1'b0;
`ifdef RD_SW_TIMEOUT_EN
      ack_err_reg    <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (frame_start) begin
            h_reg          <= h_clamp;
            line_beats_reg <= line_beats_in;
            line_cnt_reg   <= 12'd0;
            line_off_reg   <= 32'd0;
            rd_sw_reg      <= 1'b1;
`ifdef RD_SW_TIMEOUT_EN
            ack_cnt_reg    <= '0;
`endif
            state_reg      <= S_REQ;
          end
        end

        S_REQ: begin
          if (rd_sw_ack) begin
            base_reg  <= rd_start_addr;
            rd_sw_reg <= 1'b0;
            state_reg <= S_LINE;
          end
`ifdef RD_SW_TIMEOUT_EN
          else if (ack_cnt_reg == ACK_CNT_LAST) begin
            // Give up on the switch; base_reg keeps the last good bank.
            ack_err_reg <= 1'b1;
            rd_sw_reg   <= 1'b0;
            state_reg   <= S_LINE;
          end else begin
            ack_cnt_reg <= ack_cnt_reg + 1'b1;
          end
`endif
        end

        S_LINE: begin
          burst_addr_reg <= base_reg + line_off_reg;
          rem_reg        <= line_beats_reg;
          // Zero lines or zero beats per line: nothing to request.
          if (h_reg == 12'd0 || line_beats_reg == 32'd0) begin
            frame_done_reg <= 1'b1;
            state_reg      <= S_FIN;
          end else begin
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (space_ok) begin
            cmd_valid_reg <= 1'b1;
            cmd_len_reg   <= (rem_reg >= 32'(BURST_LEN)) ? LEN_MAX
                                                         : (rem_reg[7:0] - 8'd1);
            state_reg     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // burst_addr_reg and cmd_len_reg only move on acceptance, so the
          // command is held stable under backpressure.
          if (cmd_ready) begin
            cmd_valid_reg  <= 1'b0;
            burst_addr_reg <= burst_addr_reg + BURST_BYTES;
            rem_reg        <= rem_after;
            if (rem_after != 32'd0) begin
              state_reg <= S_WAIT;
            end else begin
              line_cnt_reg <= line_cnt_reg + 12'd1;
              line_off_reg <= line_off_reg + STRIDE;
              if (line_cnt_reg + 12'd1 == h_reg) begin
                frame_done_reg <= 1'b1;
                state_reg      <= S_FIN;
              end else begin
                state_reg <= S_LINE;
              end
            end
          end
        end

        S_FIN: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_sw      = rd_sw_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign cmd_addr   = burst_addr_reg;
  assign cmd_len    = cmd_len_reg;
  assign frame_done = frame_done_reg;
  assign frame_busy = (state_reg != S_IDLE);
  // Reported in the same cycle the extra frame_start arrives; the frame in
  // flight is not disturbed.
  assign frame_drop = frame_start && (state_reg != S_IDLE);

`ifdef RD_SW_TIMEOUT_EN
  assign ack_err = ack_err_reg;
`else
  assign ack_err = 1'b0;
  logic [31:0] unused_ack_timeout;
  assign unused_ack_timeout = 32'(ACK_TIMEOUT);
`endif

endmodule

// File: doc/frame_rd_cmd_gen.md
Name: frame_rd_cmd_gen

Overview:
- Read-side initiator for the frame buffer bank switcher, running on ddr_clk.
- At each display frame start it requests a read-bank switch with rd_sw and waits for rd_sw_ack.
- It latches the returned rd_start_addr, then issues one AXI read burst command per burst slot, line by line, until the whole frame has been requested.
- It sits between the bank switcher and the AXI read master / read FIFO.

Parameters:
- MAX_VID_WIDTH, 1920, pixels per line of the frame-buffer layout; sets the line stride.
- MAX_VID_HIGHT, 1080, maximum lines per frame.
- VID_DATA_WIDTH, 16, bits per pixel.
- AXI_DATA_WIDTH, 256, AXI data bus width in bits; AXI_BYTES = AXI_DATA_WIDTH/8.
- BURST_LEN, 16, maximum beats per burst command (1..256).
- ACK_TIMEOUT, 1024, cycles to wait for rd_sw_ack; used only with the optional feature.

Ports:
- ddr_clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse marking a new output frame (ddr_clk domain).
- vid_width  in  12  active pixels per line; sampled on the accepted frame_start.
- vid_height  in  12  active lines; sampled on the accepted frame_start.
- rd_sw  out  1  bank-switch request, level.
- rd_sw_ack  in  1  one-cycle acknowledge from the bank switcher.
- rd_start_addr  in  32  base byte address of the read bank.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  burst command accepted.
- cmd_addr  out  32  burst start byte address.
- cmd_len  out  8  beats-1 (AXI ARLEN encoding).
- space_ok  in  1  downstream FIFO can absorb BURST_LEN beats.
- frame_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last command is accepted.
- frame_drop  out  1  one-cycle pulse when frame_start arrives while busy.
- ack_err  out  1  one-cycle pulse on ack timeout (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; state IDLE; base, line and burst counters 0.
- Derived quantities:
  - Line stride = MAX_VID_WIDTH*VID_DATA_WIDTH/8, a constant.
  - Line bytes = w*VID_DATA_WIDTH/8, where w = min(vid_width, MAX_VID_WIDTH).
  - Line beats = ceil(line bytes / AXI_BYTES).
  - h = min(vid_height, MAX_VID_HIGHT).
  - All address arithmetic is 32-bit and wraps modulo 2^32.
- State IDLE:
  - frame_start -> sample w and h; go to REQ.
  - frame_busy = 0 only in IDLE.
- State REQ:
  - rd_sw = 1, held until rd_sw_ack is seen.
  - In the cycle rd_sw_ack = 1, latch rd_start_addr as base (the address is valid in that same cycle).
  - Next cycle: rd_sw = 0; go to LINE. rd_sw therefore has a rising edge per frame and stays low at least 1 cycle between requests.
- State LINE:
  - line_addr = base + line*stride; remaining beats = line beats.
  - If h = 0 or w = 0 -> go to FIN.
  - Otherwise -> WAIT.
- State WAIT:
  - When space_ok = 1 -> go to ISSUE.
- State ISSUE:
  - cmd_valid = 1, with cmd_addr = line_addr + k*BURST_LEN*AXI_BYTES and cmd_len = min(remaining, BURST_LEN) - 1.
  - cmd_addr and cmd_len stay stable while cmd_valid = 1 and cmd_ready = 0.
  - On cmd_valid & cmd_ready: subtract the beats issued; k += 1.
    - If remaining > 0 -> go to WAIT.
    - Else line += 1; if line = h -> go to FIN, else -> LINE.
- State FIN:
  - frame_done pulses 1 cycle; go to IDLE.
- Throughput: at most one command per 2 cycles (WAIT -> ISSUE).
- Latency: frame_start to rd_sw = 1 cycle.
- frame_start in any state other than IDLE:
  - Ignored; frame_drop pulses in the same cycle the frame_start is seen.
  - The current frame continues unaffected.
- rd_sw_ack outside REQ: ignored.
- Reset asserted mid-frame: next cycle all outputs are 0, including rd_sw and cmd_valid; any pending command is abandoned.

Optional Feature:
- Macro: RD_SW_TIMEOUT_EN.
- With the macro defined:
  - A REQ-state counter counts cycles waiting for rd_sw_ack.
  - If the count reaches ACK_TIMEOUT with no ack: ack_err pulses, rd_sw drops, and the frame proceeds to LINE using the previously latched base (0 after reset).
- Without the macro: REQ waits indefinitely; ack_err is constant 0.

Test Plan:
- Case 1: vid_width=1920, vid_height=2, ack returns 2 cycles after rd_sw with rd_start_addr=0x0010_0000; cmd_ready and space_ok held 1.
  - Expect per line: 7 commands with cmd_len=15, then 1 with cmd_len=7.
  - Line 0 addresses: 0x100000, 0x100200, ... 0x100E00.
  - Line 1 starts at 0x100F00.
  - frame_done pulses once after the 16th command.
- Case 2: vid_width=640, vid_height=1.
  - Expect commands of 16, 16 and 8 beats (cmd_len 15, 15, 7) at base+0x000, +0x200, +0x400.
- Case 3: vid_width=100, vid_height=3, base=0.
  - Expect one command per line with cmd_len=6, at addresses 0x0000, 0x0F00, 0x1E00.
- Case 4: hold cmd_ready=0 for 5 cycles and space_ok=0 for 4 cycles mid-line.
  - cmd_addr/cmd_len stay stable while stalled, and cmd_valid stays low while space_ok=0.
  - No command is lost or duplicated.
- Case 5: frame_start during ISSUE -> frame_drop pulses exactly 1 cycle and the frame completes normally. Then vid_height=0 -> rd_sw handshake occurs, zero commands are issued, frame_done pulses.
- Case 6: assert rst mid-line -> all outputs 0 next cycle.
  - With RD_SW_TIMEOUT_EN, ACK_TIMEOUT=8 and no ack: ack_err pulses 8 cycles after rd_sw rises, and commands then use base 0.
